// File: rtl/turret_pkg.sv
// Shared opcodes, FSM state types and default timing for the turret controller.
package turret_pkg;

  localparam logic [7:0] OP_PAN  = 8'h50;
  localparam logic [7:0] OP_TILT = 8'h54;
  localparam logic [7:0] OP_FIRE = 8'h46;
  localparam logic [7:0] OP_STAT = 8'h53;

  localparam int unsigned CLKS_PER_BIT_DEF = 87;
  localparam int unsigned PWM_PERIOD_DEF   = 200000;
  localparam int unsigned PWM_MIN_DEF      = 10000;
  localparam int unsigned PWM_STEP_DEF     = 39;
  localparam int unsigned FIRE_CYCLES_DEF  = 500000;
  localparam int unsigned TACH_GATE_DEF    = 1000000;

  typedef enum logic [1:0] {CMD_IDLE, CMD_GOT_OP, CMD_EXEC} cmd_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] data;
  } cmd_t;

  function automatic logic op_known(input logic [7:0] b);
    return (b == OP_PAN) || (b == OP_TILT) || (b == OP_FIRE) || (b == OP_STAT);
  endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART engines: mid-bit sampling receiver with false-start/framing rejection,
// and a shift-register transmitter idling high.
import turret_pkg::*;

module uart_8n1 #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_e   rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_vld_q, rx_vld_d;
  logic        rx_prev_q;

  logic [9:0]  tx_sh_q;
  logic [3:0]  tx_bits_q;
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_sh_q   <= '0;
      rx_bit_q  <= '0;
      rx_vld_q  <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_bit_q  <= rx_bit_d;
      rx_vld_q  <= rx_vld_d;
      rx_prev_q <= rx_i;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_sh_d  = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_vld_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_i) rx_st_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_i ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_i, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == LAST) begin
        rx_st_d  = RX_IDLE;
        rx_vld_d = rx_i;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign rx_data_o  = rx_sh_q;
  assign rx_valid_o = rx_vld_q;

  // Shifting in ones keeps the line high between and after frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sh_q   <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_bits_q == 4'd0) begin
      if (tx_start_i) begin
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_bits_q <= 4'd10;
        tx_cnt_q  <= '0;
      end
    end else if (tx_cnt_q == LAST) begin
      tx_cnt_q  <= '0;
      tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
      tx_bits_q <= tx_bits_q - 4'd1;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign tx_busy_o = (tx_bits_q != 4'd0);
  assign tx_o      = tx_sh_q[0];

endmodule

// File: rtl/turret_ctrl_top.sv
// Turret controller top: command decode, status reply, servo PWM, fire, tach, aux bridge.
// Define AUTO_FIRE_EN to fire on a rising edge of the target detect.
import turret_pkg::*;

module turret_ctrl_top #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned PWM_PERIOD   = PWM_PERIOD_DEF,
  parameter int unsigned PWM_MIN      = PWM_MIN_DEF,
  parameter int unsigned PWM_STEP     = PWM_STEP_DEF,
  parameter int unsigned FIRE_CYCLES  = FIRE_CYCLES_DEF,
  parameter int unsigned TACH_GATE    = TACH_GATE_DEF
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  input  logic RX,
  output logic TX,
  input  logic UART_0_RXD,
  output logic UART_0_TXD,
  input  logic UART_1_RXD,
  output logic UART_1_TXD,
  input  logic ADCDirectInput_0,
  input  logic VAREF1,
  input  logic TACHIN,
  output logic PWM,
  output logic PWM_0,
  output logic GPIO_15_OUT
);

  // Bit order: {VAREF1, ADC, TACHIN, UART_1_RXD, UART_0_RXD, RX}; serial lines reset idle-high.
  localparam logic [5:0] SYNC_RST = 6'b000111;

  logic [5:0] sync1_q, sync2_q;
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {VAREF1, ADCDirectInput_0, TACHIN, UART_1_RXD, UART_0_RXD, RX};
      sync2_q <= sync1_q;
    end
  end

  assign UART_0_TXD = sync2_q[2];
  assign UART_1_TXD = sync2_q[1];

  logic       detect;
  logic [7:0] rx_byte;
  logic       rx_vld, tx_busy, tx_start;
  logic [7:0] tx_data;

  assign detect = sync2_q[4] & sync2_q[5];

  uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk_i      (SYSCLK),
    .rst_i      (SYSRESET),
    .rx_i       (sync2_q[0]),
    .rx_data_o  (rx_byte),
    .rx_valid_o (rx_vld),
    .tx_data_i  (tx_data),
    .tx_start_i (tx_start),
    .tx_busy_o  (tx_busy),
    .tx_o       (TX)
  );

  cmd_state_e st_q, st_d;
  cmd_t       cmd_q, cmd_d;
  logic       exec;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      st_q  <= CMD_IDLE;
      cmd_q <= '0;
    end else begin
      st_q  <= st_d;
      cmd_q <= cmd_d;
    end
  end

  // Unknown bytes in IDLE are dropped so the link resyncs on the next opcode.
  always_comb begin
    st_d  = st_q;
    cmd_d = cmd_q;
    unique case (st_q)
      CMD_IDLE: if (rx_vld && op_known(rx_byte)) begin
        cmd_d.op = rx_byte;
        st_d     = CMD_GOT_OP;
      end
      CMD_GOT_OP: if (rx_vld) begin
        cmd_d.data = rx_byte;
        st_d       = CMD_EXEC;
      end
      CMD_EXEC: st_d = CMD_IDLE;
      default:  st_d = CMD_IDLE;
    endcase
  end

  assign exec = (st_q == CMD_EXEC);

  logic [31:0] fire_cnt_q;
  logic        fire_active, fire_trig, auto_fire;
  assign fire_active = (fire_cnt_q != 32'd0);
  assign GPIO_15_OUT = fire_active;

`ifdef AUTO_FIRE_EN
  logic detect_prev_q;
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) detect_prev_q <= 1'b0;
    else          detect_prev_q <= detect;
  end
  assign auto_fire = detect && !detect_prev_q;
`else
  assign auto_fire = 1'b0;
`endif

  assign fire_trig = (exec && cmd_q.op == OP_FIRE) || auto_fire;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET)          fire_cnt_q <= '0;
    else if (fire_active)  fire_cnt_q <= fire_cnt_q - 32'd1;
    else if (fire_trig)    fire_cnt_q <= FIRE_CYCLES;
  end

  logic [7:0] tach_cnt_q, tach_latched_q;
  logic [31:0] gate_q;
  logic       tach_prev_q, tach_edge;
  assign tach_edge = sync2_q[3] && !tach_prev_q;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      tach_prev_q    <= 1'b0;
      gate_q         <= '0;
      tach_cnt_q     <= '0;
      tach_latched_q <= '0;
    end else begin
      tach_prev_q <= sync2_q[3];
      if (gate_q == TACH_GATE - 1) begin
        gate_q         <= '0;
        tach_latched_q <= tach_cnt_q;
        tach_cnt_q     <= {7'd0, tach_edge};
      end else begin
        gate_q <= gate_q + 32'd1;
        if (tach_edge && tach_cnt_q != 8'hFF) tach_cnt_q <= tach_cnt_q + 8'd1;
      end
    end
  end

  logic       stat_pend_q, stat_req;
  logic [7:0] stat_b2_q;
  assign stat_req = exec && cmd_q.op == OP_STAT && !tx_busy && !stat_pend_q;
  assign tx_start = stat_req || (stat_pend_q && !tx_busy);
  assign tx_data  = stat_req ? tach_latched_q : stat_b2_q;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      stat_pend_q <= 1'b0;
      stat_b2_q   <= '0;
    end else if (stat_req) begin
      stat_pend_q <= 1'b1;
      stat_b2_q   <= {5'b0, detect, fire_active, 1'b1};
    end else if (stat_pend_q && !tx_busy) begin
      stat_pend_q <= 1'b0;
    end
  end

  // Lane 0 = pan, lane 1 = tilt; commanded positions take effect only at frame wrap.
  logic [1:0][7:0]  pos_cmd_q, pos_act_q;
  logic [1:0][31:0] thr;
  logic [1:0]       pwm_q, pwm_d;
  logic [31:0]      frm_q;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      thr[c]   = PWM_MIN + 32'(pos_act_q[c]) * PWM_STEP;
      pwm_d[c] = (frm_q < thr[c]);
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      pos_cmd_q <= {8'd128, 8'd128};
      pos_act_q <= {8'd128, 8'd128};
      frm_q     <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_q <= pwm_d;
      if (exec && cmd_q.op == OP_PAN)  pos_cmd_q[0] <= cmd_q.data;
      if (exec && cmd_q.op == OP_TILT) pos_cmd_q[1] <= cmd_q.data;
      if (frm_q == PWM_PERIOD - 1) begin
        frm_q     <= '0;
        pos_act_q <= pos_cmd_q;
      end else begin
        frm_q <= frm_q + 32'd1;
      end
    end
  end

  assign PWM   = pwm_q[0];
  assign PWM_0 = pwm_q[1];

endmodule

// File: tb/tb_turret_ctrl_top.sv
// Directed bench for turret_ctrl_top with timing scaled down for short runs.
module tb_turret_ctrl_top;

  localparam int CPB    = 8;
  localparam int PERIOD = 1000;
  localparam int PMIN   = 100;
  localparam int PSTEP  = 3;
  localparam int FIREC  = 500;
  localparam int GATE   = 2000;

  logic SYSCLK = 1'b0;
  logic SYSRESET = 1'b1;
  logic RX = 1'b1, UART_0_RXD = 1'b1, UART_1_RXD = 1'b1;
  logic ADCDirectInput_0 = 1'b0, VAREF1 = 1'b0, TACHIN = 1'b0;
  logic TX, UART_0_TXD, UART_1_TXD, PWM, PWM_0, GPIO_15_OUT;

  int total = 0;
  int bad   = 0;

  always #5 SYSCLK = ~SYSCLK;

  turret_ctrl_top #(
    .CLKS_PER_BIT(CPB), .PWM_PERIOD(PERIOD), .PWM_MIN(PMIN),
    .PWM_STEP(PSTEP), .FIRE_CYCLES(FIREC), .TACH_GATE(GATE)
  ) dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .RX(RX), .TX(TX),
    .UART_0_RXD(UART_0_RXD), .UART_0_TXD(UART_0_TXD),
    .UART_1_RXD(UART_1_RXD), .UART_1_TXD(UART_1_TXD),
    .ADCDirectInput_0(ADCDirectInput_0), .VAREF1(VAREF1), .TACHIN(TACHIN),
    .PWM(PWM), .PWM_0(PWM_0), .GPIO_15_OUT(GPIO_15_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  task automatic do_reset(input int n);
    @(negedge SYSCLK);
    SYSRESET = 1'b1;
    cyc(n);
    SYSRESET = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge SYSCLK);
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      cyc(CPB);
    end
    cyc(2);
  endtask

  task automatic get(output logic [7:0] b, output logic ok);
    int t;
    t  = 0;
    ok = 1'b1;
    b  = '0;
    while (TX !== 1'b0 && t < 1000) begin
      @(negedge SYSCLK);
      t++;
    end
    if (TX !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    cyc(CPB / 2);
    for (int i = 0; i < 8; i++) begin
      cyc(CPB);
      b[i] = TX;
    end
    cyc(CPB);
    if (TX !== 1'b1) ok = 1'b0;
  endtask

  task automatic status(input string tag, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] b1, b2;
    logic ok1, ok2;
    fork
      begin send(8'h53); send(8'h00); end
      begin get(b1, ok1); get(b2, ok2); end
    join
    chk({tag, "_ok1"}, 32'(ok1), 32'd1);
    chk({tag, "_b1"}, 32'(b1), 32'(e1));
    chk({tag, "_ok2"}, 32'(ok2), 32'd1);
    chk({tag, "_b2"}, 32'(b2), 32'(e2));
  endtask

  task automatic meas(output int w0, output int w1, output int per, output logic t_at_rise);
    int t;
    logic p, rise;
    w0 = 0; w1 = 0; per = 0; t = 0; t_at_rise = 1'b0;
    p = PWM;
    do begin
      @(negedge SYSCLK);
      t++;
      rise = PWM && !p;
      p = PWM;
    end while (!rise && t < 3 * PERIOD);
    if (!rise) return;
    t_at_rise = PWM_0;
    w0 = 1; w1 = PWM_0 ? 1 : 0; per = 1;
    do begin
      @(negedge SYSCLK);
      rise = PWM && !p;
      p = PWM;
      if (!rise) begin
        per++;
        w0 += PWM ? 1 : 0;
        w1 += PWM_0 ? 1 : 0;
      end
    end while (!rise && per < 3 * PERIOD);
  endtask

  task automatic meas_fire(output int w);
    int t;
    t = 0;
    w = 0;
    while (GPIO_15_OUT !== 1'b1 && t < 2000) begin
      @(negedge SYSCLK);
      t++;
    end
    if (GPIO_15_OUT !== 1'b1) begin
      w = -1;
      return;
    end
    while (GPIO_15_OUT === 1'b1 && w < 5000) begin
      w++;
      @(negedge SYSCLK);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, per, fw;
    logic tr;

    cyc(10);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_fire", 32'(GPIO_15_OUT), 32'd0);
    chk("rst_pwm", 32'(PWM), 32'd0);
    chk("rst_pwm0", 32'(PWM_0), 32'd0);
    chk("rst_u0txd", 32'(UART_0_TXD), 32'd1);
    chk("rst_u1txd", 32'(UART_1_TXD), 32'd1);
    SYSRESET = 1'b0;

    // Reset position 128: 100 + 128*3 = 484
    meas(w0, w1, per, tr);
    chk("rst_pan_w", 32'(w0), 32'd484);
    chk("rst_tilt_w", 32'(w1), 32'd484);
    chk("rst_period", 32'(per), 32'(PERIOD));
    chk("rst_same_rise", 32'(tr), 32'd1);

    send(8'h50); send(8'h00); send(8'h54); send(8'hFF);
    meas(w0, w1, per, tr);
    chk("pan0_w", 32'(w0), 32'd100);
    chk("tilt255_w", 32'(w1), 32'd865);
    chk("pt_period", 32'(per), 32'(PERIOD));

    fork
      meas_fire(fw);
      begin send(8'h46); send(8'h00); cyc(100); send(8'h46); send(8'h00); end
    join
    chk("fire_width", 32'(fw), 32'(FIREC));
    cyc(100);
    chk("fire_no_retrig", 32'(GPIO_15_OUT), 32'd0);

    send(8'h46); send(8'h00);
    cyc(50);
    chk("fire_mid", 32'(GPIO_15_OUT), 32'd1);
    @(negedge SYSCLK);
    SYSRESET = 1'b1;
    cyc(2);
    chk("rst_mid_fire", 32'(GPIO_15_OUT), 32'd0);
    chk("rst_mid_pwm", 32'(PWM), 32'd0);
    chk("rst_mid_tx", 32'(TX), 32'd1);

    do_reset(2);
    repeat (37) begin
      TACHIN = 1'b1; cyc(10);
      TACHIN = 1'b0; cyc(10);
    end
    cyc(1400);
    status("tach37", 8'h25, 8'h01);

    do_reset(2);
    repeat (300) begin
      TACHIN = 1'b1; cyc(2);
      TACHIN = 1'b0; cyc(2);
    end
    cyc(900);
    status("tach300", 8'hFF, 8'h01);

    // 0x12 must be discarded; pan = 0x40 -> 100 + 64*3 = 292
    send(8'h12); send(8'h50); send(8'h40);
    meas(w0, w1, per, tr);
    chk("resync_pan_w", 32'(w0), 32'd292);
    chk("resync_tilt_w", 32'(w1), 32'd484);

    @(negedge SYSCLK);
    UART_0_RXD = 1'b0;
    @(posedge SYSCLK); #1;
    chk("br01_lat1", 32'(UART_1_TXD), 32'd1);
    @(posedge SYSCLK); #1;
    chk("br01_lat2", 32'(UART_1_TXD), 32'd0);
    @(negedge SYSCLK);
    UART_1_RXD = 1'b0;
    @(posedge SYSCLK); #1;
    chk("br10_lat1", 32'(UART_0_TXD), 32'd1);
    @(posedge SYSCLK); #1;
    chk("br10_lat2", 32'(UART_0_TXD), 32'd0);
    @(negedge SYSCLK);
    UART_0_RXD = 1'b1;
    UART_1_RXD = 1'b1;

    do_reset(2);
    ADCDirectInput_0 = 1'b1;
    VAREF1 = 1'b1;
    cyc(10);
`ifdef AUTO_FIRE_EN
    chk("auto_fire", 32'(GPIO_15_OUT), 32'd1);
    status("detect", 8'h00, 8'h07);
`else
    chk("no_auto_fire", 32'(GPIO_15_OUT), 32'd0);
    status("detect", 8'h00, 8'h05);
`endif

    VAREF1 = 1'b0;
    do_reset(2);
    cyc(20);
    chk("vref0_no_fire", 32'(GPIO_15_OUT), 32'd0);
    status("vref0", 8'h00, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turret_ctrl_top.md
Name: turret_ctrl_top

Overview:
- Fabric top level of the turret controller.
- Decodes 2-byte commands from a serial link on RX, returns status on TX, and drives two RC-servo PWM outputs (pan PWM, tilt PWM_0) and a fire solenoid GPIO_15_OUT.
- Measures a tachometer input and samples a 1-bit target comparator.
- Also bridges two auxiliary UARTs (UART_0 and UART_1) to each other.

Parameters:
- CLKS_PER_BIT, 87, SYSCLK cycles per UART bit (10 MHz / 115200).
- PWM_PERIOD, 200000, servo frame length in cycles (20 ms).
- PWM_MIN, 10000, pulse width at position 0 (1 ms).
- PWM_STEP, 39, cycles added per position LSB.
- FIRE_CYCLES, 500000, fire pulse length (50 ms).
- TACH_GATE, 1000000, tach counting window (100 ms).

Ports:
- SYSCLK  in  1  system clock, 10 MHz.
- SYSRESET  in  1  synchronous, active-high reset.
- RX  in  1  command UART receive, idle high.
- TX  out  1  command UART transmit, idle high.
- UART_0_RXD  in  1  aux UART 0 receive.
- UART_0_TXD  out  1  aux UART 0 transmit.
- UART_1_RXD  in  1  aux UART 1 receive.
- UART_1_TXD  out  1  aux UART 1 transmit.
- ADCDirectInput_0  in  1  target comparator output, high = target.
- VAREF1  in  1  comparator reference valid; detect is qualified by it.
- TACHIN  in  1  tachometer pulse input.
- PWM  out  1  pan servo PWM.
- PWM_0  out  1  tilt servo PWM.
- GPIO_15_OUT  out  1  fire solenoid drive, high = fire.

Behaviour:
- Clocking and reset:
  - One clock domain, SYSCLK.
  - SYSRESET is synchronous and active-high.
  - Reset values: TX=1, UART_0_TXD=1, UART_1_TXD=1, PWM=0, PWM_0=0, GPIO_15_OUT=0.
  - On reset: pan=tilt=128, tach_latched=0, all counters 0, command FSM in IDLE.
- Input synchronisation:
  - RX, UART_x_RXD, TACHIN, ADCDirectInput_0 and VAREF1 each pass through a 2-flop synchroniser.
- Aux bridge:
  - UART_0_TXD = synced UART_1_RXD.
  - UART_1_TXD = synced UART_0_RXD.
  - Latency is 2 cycles.
- Command UART format: 8N1, LSB first.
- UART receiver:
  - Detects the start bit on the falling edge, samples at mid-bit (CLKS_PER_BIT/2).
  - Rejects a false start if the line is high at mid-start.
  - Framing error (stop bit = 0): byte dropped.
- Command FSM states: IDLE -> GOT_OP -> EXEC -> IDLE.
  - The first byte is the opcode; the second is data.
  - 0x50: pan = data.
  - 0x54: tilt = data.
  - 0x46: fire; data is ignored.
  - 0x53: status; data is ignored.
  - Unknown opcode in IDLE: byte discarded, FSM stays in IDLE (resync).
  - New pan/tilt values apply at the start of the next PWM frame; no glitch mid-frame.
- Status response: the transmitter sends two bytes back-to-back.
  - Byte 1 = tach_latched.
  - Byte 2 = {5'b0, detect, fire_active, 1'b1}.
  - A status request while TX is busy is dropped.
- PWM:
  - A shared frame counter runs 0..PWM_PERIOD-1.
  - Each output is high while count < PWM_MIN + pos*PWM_STEP.
  - Range 10000..19945 cycles. Both outputs rise on the same cycle.
- Fire:
  - GPIO_15_OUT goes high the cycle after EXEC of 0x46 and stays high FIRE_CYCLES cycles.
  - Fire commands received while it is high are ignored; there is no retrigger extension.
- Tach:
  - Counts synced TACHIN rising edges over TACH_GATE cycles.
  - At window end, the count is latched into tach_latched (saturating at 255) and the counter restarts at 0.
  - An edge arriving on the window-end cycle counts in the new window.
- Detect: detect = synced ADCDirectInput_0 AND synced VAREF1.
- Reset mid-operation: any frame, transmission or fire pulse in progress is abandoned immediately and outputs take their reset values.

Optional Feature:
- Macro AUTO_FIRE_EN.
- When defined: a rising edge of detect starts a fire pulse, with the same rules as command 0x46 (ignored while the pulse is active).
- When undefined: detect only appears in the status byte and never fires.

Decomposition:
- Package turret_pkg holds:
  - opcode constants OP_PAN=0x50, OP_TILT=0x54, OP_FIRE=0x46, OP_STAT=0x53;
  - the FSM state typedef;
  - default timing constants.
- One natural sub-module, uart_8n1, holds the RX and TX engines, parameterised by CLKS_PER_BIT. It is instantiated once for the command link.

Test Plan:
- Reset: assert SYSRESET 10 cycles -> TX=1, GPIO_15_OUT=0. First PWM high pulse = 10000+128*39 = 14992 cycles, period 200000.
- RX bytes 0x50,0x00 then 0x54,0xFF -> next frame: PWM high 10000 cycles, PWM_0 high 19945 cycles.
- RX 0x46,0x00 -> GPIO_15_OUT high exactly 500000 cycles. A second 0x46 sent mid-pulse -> no extension.
- TACHIN at 37 rising edges per 100 ms window, then RX 0x53,0x00 -> TX emits 0x25 then 0x01 (ADC=0). With 300 edges, first byte = 0xFF.
- RX 0x12 then 0x50,0x40 -> 0x12 discarded, pan=0x40. UART_0_RXD toggle -> UART_1_TXD follows after 2 cycles.
- AUTO_FIRE_EN defined: ADCDirectInput_0=1 with VAREF1=1 -> fire pulse starts. With VAREF1=0 -> no fire.
